// File: rtl/m00_sched_pkg.sv
// ---------------------------------------------------------------------------
// m00_sched_pkg
// Shared types and helpers for the M00_AXI transaction scheduler.
//   sched_state_t : FSM state encoding (IDLE -> LAUNCH -> WAIT -> RESP)
//   timer_w()     : width of the WAIT-state watchdog counter
// ---------------------------------------------------------------------------
package m00_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } sched_state_t;

   // The watchdog only ever needs to reach TIMEOUT_CYCLES-1.
   function automatic int timer_w(input int timeout_cycles);
      return $clog2(timeout_cycles);
   endfunction

endpackage

// File: rtl/m00_rr_pick.sv
// ---------------------------------------------------------------------------
// m00_rr_pick
// Combinational round-robin picker: selects the first set req_valid bit at
// or after ptr, wrapping around to bit 0.
//   req_valid : per-requester request bits
//   ptr       : highest-priority index for this pick
//   any       : at least one request is set
//   idx       : selected requester (0 when any is low)
// ---------------------------------------------------------------------------
module m00_rr_pick
   import m00_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   int         j;
   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down to offset 0 so that the candidate
   // closest to ptr is the last one written and therefore wins.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      j    = 0;
      cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j    = (int'(ptr) + k) % NUM_REQ;
         cand = IDX_W'(j);
         if (req_valid[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/m00_txn_scheduler.sv
// ---------------------------------------------------------------------------
// m00_txn_scheduler
// Shares one M00_AXI burst master engine between NUM_REQ requesters using
// round-robin arbitration. One transaction is in flight at a time.
//   ACLK, ARESETN           : clock, asynchronous active-low reset
//   req_valid/addr/len/write: per-requester burst requests (packed vectors)
//   req_ready               : one-hot accept pulse
//   rsp_valid, rsp_error    : one-hot completion pulse and its error status
//   eng_init                : one-cycle start pulse to the engine
//   eng_addr/len/write      : latched command, stable until back in IDLE
//   eng_done, eng_error     : engine completion level and error flag
//   busy, grant_id          : activity flag and current/last granted index
// ---------------------------------------------------------------------------
module m00_txn_scheduler
   import m00_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int LEN_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   input  logic [NUM_REQ-1:0]            req_write,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic                          rsp_error,
   output logic                          eng_init,
   output logic [ADDR_WIDTH-1:0]         eng_addr,
   output logic [LEN_WIDTH-1:0]          eng_len,
   output logic                          eng_write,
   input  logic                          eng_done,
   input  logic                          eng_error,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMR_W = timer_w(TIMEOUT_CYCLES);

   sched_state_t     state_reg, state_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;
   logic [IDX_W-1:0] grant_reg, grant_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [LEN_WIDTH-1:0]  len_reg, len_next;
   logic             write_reg, write_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic             err_reg, err_next;
   logic             done_q;
   logic             done_rise;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;

   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
   logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];

   m00_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr_reg),
      .any       (pick_any),
      .idx       (pick_idx)
   );

   // Unpack the per-requester payloads and decode the one-hot handshakes.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign len_arr[gi]   = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
         assign req_ready[gi] = (state_reg == IDLE) && pick_any && (pick_idx == IDX_W'(gi));
         assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == IDX_W'(gi));
      end
   endgenerate

   // A done level left high by the previous transaction must not complete
   // the current one, so only a fresh rising edge counts.
   assign done_rise = eng_done & ~done_q;

   assign eng_init  = (state_reg == LAUNCH);
   assign rsp_error = (state_reg == RESP) & err_reg;
   assign busy      = (state_reg != IDLE);
   assign eng_addr  = addr_reg;
   assign eng_len   = len_reg;
   assign eng_write = write_reg;
   assign grant_id  = grant_reg;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         grant_reg <= '0;
         addr_reg  <= '0;
         len_reg   <= '0;
         write_reg <= 1'b0;
         timer_reg <= '0;
         err_reg   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         grant_reg <= grant_next;
         addr_reg  <= addr_next;
         len_reg   <= len_next;
         write_reg <= write_next;
         timer_reg <= timer_next;
         err_reg   <= err_next;
         done_q    <= eng_done;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      grant_next = grant_reg;
      addr_next  = addr_reg;
      len_next   = len_reg;
      write_next = write_reg;
      timer_next = timer_reg;
      err_next   = err_reg;
      unique case (state_reg)
         IDLE: begin
            if (pick_any) begin
               grant_next = pick_idx;
               addr_next  = addr_arr[pick_idx];
               len_next   = len_arr[pick_idx];
               write_next = req_write[pick_idx];
               ptr_next   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            timer_next = '0;
            state_next = WAIT;
         end
         WAIT: begin
            timer_next = timer_reg + 1'b1;
            // done has priority over a simultaneous watchdog expiry
            if (done_rise) begin
               err_next   = eng_error;
               state_next = RESP;
            end else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               err_next   = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
